// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencer for the MIPS core.
// Steps BOOT -> FETCH -> EXEC, selects the next PC, counts retirements.
//
// Ports:
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   IMemReady       instruction word at PC returned this cycle
//   Stall, Halt     hold instruction in execute / instruction is a halt
//   Branch, Jump,   redirect requests, sampled only in EXEC when not
//   JumpReg           stalled (priority JumpReg > Jump > Branch)
//   Simm            sign-extended immediate for branch offsets
//   JIndex          26-bit jump index field
//   RegTarget       register value for JR/JALR
//   PC, PCPlus4     current PC and combinational PC+4
//   FetchReq        fetch request to instruction memory
//   InstrValid      instruction in execute is valid
//   Halted          core halted (left only through RST)
//   AlignErr        sticky misaligned JR target flag
//   RetireCount     retired-instruction counter (wraps)
//
// Build option: define PC_ALIGN_CHECK_EN to trap misaligned JR targets
// (AlignErr + halt). Without it the JR target's low two bits are cleared
// and AlignErr is tied 0.

module pc_fetch_unit #(
    parameter int              WL       = 32,
    parameter logic [WL-1:0]   RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IMemReady,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          Branch,
    input  logic          Jump,
    input  logic          JumpReg,
    input  logic [WL-1:0] Simm,
    input  logic [25:0]   JIndex,
    input  logic [WL-1:0] RegTarget,
    output logic [WL-1:0] PC,
    output logic [WL-1:0] PCPlus4,
    output logic          FetchReq,
    output logic          InstrValid,
    output logic          Halted,
    output logic          AlignErr,
    output logic [31:0]   RetireCount
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [WL-1:0] pc_q, pc_d;
    logic [31:0]   rc_q, rc_d;
    logic          aerr_d;
    logic          aerr_q;

    logic [WL-1:0] pc_plus4;
    logic [WL-1:0] br_target;
    logic [WL-1:0] j_target;
    logic [WL-1:0] jr_target;
    logic [WL-1:0] next_pc;
    logic          jr_misaligned;

    assign pc_plus4  = pc_q + WL'(4);
    assign br_target = pc_plus4 + (Simm << 2);
    assign j_target  = {pc_plus4[WL-1:28], JIndex, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    assign jr_target     = RegTarget;
    assign jr_misaligned = JumpReg && (RegTarget[1:0] != 2'b00);
`else
    // Low bits silently dropped; a word-aligned target is always formed.
    assign jr_target     = RegTarget & {{(WL-2){1'b1}}, 2'b00};
    assign jr_misaligned = 1'b0;
`endif

    always_comb begin
        if (JumpReg)
            next_pc = jr_target;
        else if (Jump)
            next_pc = j_target;
        else if (Branch)
            next_pc = br_target;
        else
            next_pc = pc_plus4;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rc_d    = rc_q;
        aerr_d  = aerr_q;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (IMemReady)
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                // Stall freezes everything, including pending redirects.
                if (!Stall) begin
                    if (Halt) begin
                        rc_d    = rc_q + 32'd1;
                        state_d = S_HALT;
                    end else if (jr_misaligned) begin
                        // Trap: faulting JR neither retires nor moves PC.
                        aerr_d  = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        rc_d    = rc_q + 32'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            rc_q    <= '0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rc_q    <= rc_d;
            aerr_q  <= aerr_d;
        end
    end

    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign FetchReq    = (state_q == S_FETCH);
    assign InstrValid  = (state_q == S_EXEC);
    assign Halted      = (state_q == S_HALT);
    assign AlignErr    = aerr_q;
    assign RetireCount = rc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit.
// Inputs change 1ns after a rising edge; outputs are sampled there too.

module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IMemReady;
    logic        Stall;
    logic        Halt;
    logic        Branch;
    logic        Jump;
    logic        JumpReg;
    logic [31:0] Simm;
    logic [25:0] JIndex;
    logic [31:0] RegTarget;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        FetchReq;
    logic        InstrValid;
    logic        Halted;
    logic        AlignErr;
    logic [31:0] RetireCount;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.WL(32), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RST(RST), .IMemReady(IMemReady), .Stall(Stall),
        .Halt(Halt), .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg),
        .Simm(Simm), .JIndex(JIndex), .RegTarget(RegTarget),
        .PC(PC), .PCPlus4(PCPlus4), .FetchReq(FetchReq),
        .InstrValid(InstrValid), .Halted(Halted), .AlignErr(AlignErr),
        .RetireCount(RetireCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_redir();
        Branch = 0; Jump = 0; JumpReg = 0;
        Simm = '0; JIndex = '0; RegTarget = '0;
    endtask

    // From FETCH with IMemReady=1: enter EXEC, apply redirect, retire.
    task automatic redir(input logic jr, input logic j, input logic br,
                         input logic [31:0] simm, input logic [25:0] jidx,
                         input logic [31:0] rt);
        step();
        JumpReg = jr; Jump = j; Branch = br;
        Simm = simm; JIndex = jidx; RegTarget = rt;
        step();
        clr_redir();
    endtask

    initial begin
        RST = 1; IMemReady = 1; Stall = 0; Halt = 0;
        clr_redir();
        step(); step();
        chk("rst_pc", PC, 32'h0);
        chk("rst_fetchreq", FetchReq, 0);
        chk("rst_ivalid", InstrValid, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_alignerr", AlignErr, 0);
        chk("rst_rc", RetireCount, 0);
        RST = 0;
        step();
        chk("boot_fetchreq", FetchReq, 1);
        chk("seq_pc0f", PC, 32'h0);
        step();
        chk("seq_ivalid0", InstrValid, 1);
        chk("seq_pc0e", PC, 32'h0);
        step();
        chk("seq_pc4f", PC, 32'h4);
        chk("seq_rc1", RetireCount, 1);
        step();
        chk("seq_pc4e", PC, 32'h4);
        step();
        chk("seq_pc8f", PC, 32'h8);
        chk("seq_rc2", RetireCount, 2);
        chk("seq_plus4", PCPlus4, 32'hC);

        redir(1, 0, 0, 0, 0, 32'h40);
        chk("jr_40", PC, 32'h40);
        redir(0, 0, 1, 32'hFFFF_FFFE, 0, 0);
        chk("br_back", PC, 32'h3C);
        redir(1, 0, 0, 0, 0, 32'h40);
        redir(0, 0, 1, 32'h10, 0, 0);
        chk("br_fwd", PC, 32'h84);
        redir(1, 0, 0, 0, 0, 32'h1000_0000);
        redir(0, 1, 1, 32'h10, 26'h000_0100, 0);
        chk("j_over_br", PC, 32'h1000_0400);
        redir(1, 1, 0, 0, 26'h3FF_FFFF, 32'h200);
        chk("jr_over_j", PC, 32'h200);
        redir(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
        chk("br_self", PC, 32'h200);
        redir(1, 0, 0, 0, 0, 32'hFFFF_FFFC);
        chk("plus4_wrap", PCPlus4, 32'h0);
        redir(0, 0, 0, 0, 0, 0);
        chk("pc_wrap", PC, 32'h0);
        chk("rc_12", RetireCount, 12);

        step();
        Stall = 1; Branch = 1; Simm = 32'h4;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", PC, 32'h0);
            chk("stall_rc", RetireCount, 12);
            chk("stall_ivalid", InstrValid, 1);
        end
        Stall = 0;
        step();
        clr_redir();
        chk("stall_rel_pc", PC, 32'h14);
        chk("stall_rel_rc", RetireCount, 13);

        IMemReady = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wait_fetchreq", FetchReq, 1);
            chk("wait_pc", PC, 32'h14);
            chk("wait_ivalid", InstrValid, 0);
        end
        IMemReady = 1;
        step();
        chk("wait_exec", InstrValid, 1);

        Halt = 1;
        step();
        Halt = 0; Branch = 1; Simm = 32'h100;
        chk("halt_halted", Halted, 1);
        chk("halt_rc", RetireCount, 14);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_fetchreq", FetchReq, 0);
            chk("halt_stay", Halted, 1);
            chk("halt_pc", PC, 32'h14);
        end
        clr_redir();
        RST = 1;
        step();
        chk("rst_halt_pc", PC, 32'h0);
        chk("rst_halt_halted", Halted, 0);
        chk("rst_halt_rc", RetireCount, 0);
        RST = 0;

        step();
        chk("fetch_again", FetchReq, 1);
        RST = 1;
        step();
        chk("rstf_fetchreq", FetchReq, 0);
        chk("rstf_ivalid", InstrValid, 0);
        chk("rstf_rc", RetireCount, 0);
        RST = 0;
        step(); step(); step();
        chk("rstf_pc", PC, 32'h4);
        chk("rstf_rc1", RetireCount, 1);

        redir(1, 0, 0, 0, 0, 32'h102);
`ifdef PC_ALIGN_CHECK_EN
        chk("align_err", AlignErr, 1);
        chk("align_halted", Halted, 1);
        chk("align_pc", PC, 32'h4);
        chk("align_rc", RetireCount, 1);
`else
        chk("align_err", AlignErr, 0);
        chk("align_halted", Halted, 0);
        chk("align_pc", PC, 32'h100);
        chk("align_rc", RetireCount, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
